fht_stage_seq: RTL and testbench

//  Operand/coefficient sequencer that feeds fht_but. Runs all log2(N) radix-2 FHT stages over a ping-pong RAM pair.

---
 rtl/fht_pkg.sv | 33 +++
 rtl/fht_dly_line.sv | 40 ++++
 rtl/fht_stage_seq.sv | 217 +++++++++++++++++++++
 tb/tb_fht_stage_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT stage sequencer.
package fht_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fht_state_t;

    localparam int ADDR_MAX_W = 16;
    localparam int N_BIT_DEF  = 8;

    function automatic int fht_stg_w(input int n_bit);
        return (n_bit > 1) ? $clog2(n_bit) : 1;
    endfunction

    localparam int STG_W = fht_stg_w(N_BIT_DEF);

    // Reverses the low n_bit bits of addr; upper bits come back as zero.
    function automatic logic [ADDR_MAX_W-1:0] bitrev(input logic [ADDR_MAX_W-1:0] addr,
                                                     input int                    n_bit);
        logic [ADDR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_MAX_W; i++) begin
            if (i < n_bit) begin
                r[4'(i)] = addr[4'(n_bit - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_dly_line.sv
// Fixed-depth shift register that carries the write strobe and addresses
// alongside the read and butterfly pipeline.
module fht_dly_line
    import fht_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] r_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= '0;
                    end else begin
                        r_q <= i_d;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= '0;
                    end else begin
                        r_q <= g_stage[gi-1].r_q;
                    end
                end
            end
        end
    endgenerate

    assign o_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/fht_stage_seq.sv
// Butterfly address/coefficient sequencer: walks all radix-2 FHT stages over a
// ping-pong RAM pair and emits delayed write-back addresses.
module fht_stage_seq
    import fht_pkg::*;
#(
    parameter int N_BIT   = N_BIT_DEF,
    parameter int RD_LAT  = 1,
    parameter int BUT_LAT = 1
) (
    input  logic                        iCLK,
    input  logic                        iRESET,
    input  logic                        iSTART,
    output logic                        oBUSY,
    output logic                        oDONE,
    output logic                        oRD_EN,
    output logic [N_BIT-1:0]            oRD_ADDR_0,
    output logic [N_BIT-1:0]            oRD_ADDR_1,
    output logic [N_BIT-1:0]            oRD_ADDR_2,
    output logic [N_BIT-2:0]            oROM_ADDR,
    output logic                        oWR_EN,
    output logic [N_BIT-1:0]            oWR_ADDR_0,
    output logic [N_BIT-1:0]            oWR_ADDR_1,
    output logic                        oBANK,
    output logic [fht_stg_w(N_BIT)-1:0] oSTAGE
);

    localparam int PIPE_LAT = RD_LAT + BUT_LAT;
    localparam int SW       = (N_BIT == N_BIT_DEF) ? STG_W : fht_stg_w(N_BIT);
    localparam int BW       = N_BIT - 1;
    localparam int FW       = $clog2(PIPE_LAT + 1);
    localparam int DW       = 1 + 2 * N_BIT;

    localparam logic [BW-1:0]    B_LAST = '1;
    localparam logic [FW-1:0]    F_LAST = FW'(PIPE_LAT - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(N_BIT - 1);
    localparam logic [N_BIT-1:0] ONE    = N_BIT'(1);

    fht_state_t       r_state;
    logic [BW-1:0]    r_b;
    logic [FW-1:0]    r_f;
    logic [SW-1:0]    r_stage;
    logic             r_busy;
    logic             r_done;
    logic             r_bank;

    logic             r_rd_en;
    logic [N_BIT-1:0] r_rd0;
    logic [N_BIT-1:0] r_rd1;
    logic [N_BIT-1:0] r_rd2;
    logic [BW-1:0]    r_rom;
    logic [N_BIT-1:0] r_wa0;
    logic [N_BIT-1:0] r_wa1;

    logic             w_issue;
    logic [SW-1:0]    w_iss_s;
    logic [BW-1:0]    w_iss_b;
    logic [N_BIT-1:0] w_b_ext;
    logic [N_BIT-1:0] w_h;
    logic [N_BIT-1:0] w_g;
    logic [N_BIT-1:0] w_k;
    logic [N_BIT-1:0] w_lo;
    logic [N_BIT-1:0] w_hi;
    logic [N_BIT-1:0] w_mir;
    logic [SW-1:0]    w_rsh;
    logic [BW-1:0]    w_rom;
    logic [N_BIT-1:0] w_rd0;
    logic [N_BIT-1:0] w_rd1;
    logic [N_BIT-1:0] w_rd2;
    logic [DW-1:0]    w_dly_q;

    // Which butterfly (stage, index) gets presented on the outputs after this edge.
    always_comb begin
        w_issue = 1'b0;
        w_iss_s = '0;
        w_iss_b = '0;
        case (r_state)
            IDLE: begin
                w_issue = iSTART;
            end
            RUN: begin
                w_issue = (r_b != B_LAST);
                w_iss_s = r_stage;
                w_iss_b = r_b + BW'(1);
            end
            FLUSH: begin
                w_issue = (r_f == F_LAST) && (r_stage != S_LAST);
                w_iss_s = r_stage + SW'(1);
            end
            default: ;
        endcase
    end

    // g+2h-k stays below N for k>=1; the k==0 case wraps to the group's midpoint.
    always_comb begin
        w_b_ext = {1'b0, w_iss_b};
        w_h     = ONE << w_iss_s;
        w_g     = ((w_b_ext >> w_iss_s) << 1) << w_iss_s;
        w_k     = w_b_ext & (w_h - ONE);
        w_lo    = w_g + w_k;
        w_hi    = w_lo + w_h;
        w_mir   = (w_k == '0) ? (w_g + w_h) : (w_g + (w_h << 1) - w_k);
        w_rsh   = S_LAST - w_iss_s;
        w_rom   = BW'(w_k << w_rsh);
        if (w_iss_s == '0) begin
            w_rd0 = N_BIT'(bitrev(ADDR_MAX_W'(w_lo), N_BIT));
            w_rd1 = N_BIT'(bitrev(ADDR_MAX_W'(w_hi), N_BIT));
            w_rd2 = N_BIT'(bitrev(ADDR_MAX_W'(w_mir), N_BIT));
        end else begin
            w_rd0 = w_lo;
            w_rd1 = w_hi;
            w_rd2 = w_mir;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= IDLE;
            r_b     <= '0;
            r_f     <= '0;
            r_stage <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bank  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (iSTART) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_bank  <= 1'b0;
                        r_stage <= '0;
                        r_b     <= '0;
                    end
                end
                RUN: begin
                    if (r_b == B_LAST) begin
                        r_state <= FLUSH;
                        r_f     <= '0;
                    end else begin
                        r_b <= r_b + BW'(1);
                    end
                end
                FLUSH: begin
                    if (r_f == F_LAST) begin
                        r_f    <= '0;
                        r_bank <= ~r_bank;
                        if (r_stage == S_LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_stage <= r_stage + SW'(1);
                            r_b     <= '0;
                        end
                    end else begin
                        r_f <= r_f + FW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Address registers hold their last value while no butterfly is issued.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_rd_en <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_rom   <= '0;
            r_wa0   <= '0;
            r_wa1   <= '0;
        end else begin
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_rd0 <= w_rd0;
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
                r_rom <= w_rom;
                r_wa0 <= w_lo;
                r_wa1 <= w_hi;
            end
        end
    end

    fht_dly_line #(
        .W    (DW),
        .DEPTH(PIPE_LAT)
    ) u_dly (
        .i_clk  (iCLK),
        .i_rst_n(iRESET),
        .i_d    ({r_rd_en, r_wa0, r_wa1}),
        .o_q    (w_dly_q)
    );

    assign {oWR_EN, oWR_ADDR_0, oWR_ADDR_1} = w_dly_q;

    assign oBUSY      = r_busy;
    assign oDONE      = r_done;
    assign oRD_EN     = r_rd_en;
    assign oRD_ADDR_0 = r_rd0;
    assign oRD_ADDR_1 = r_rd1;
    assign oRD_ADDR_2 = r_rd2;
    assign oROM_ADDR  = r_rom;
    assign oBANK      = r_bank;
    assign oSTAGE     = r_stage;

endmodule

// File: tb/tb_fht_stage_seq.sv
// Bench for fht_stage_seq at N_BIT=3: directed vector table, hold/abort
// sequences and randomized runs against a cycle-level reference model.
module tb_fht_stage_seq;

    localparam int NB       = 3;
    localparam int NH       = 1 << (NB - 1);
    localparam int PL       = 2;
    localparam int SPS      = NH + PL;
    localparam int DONE_J   = 1 + NB * SPS;
    localparam int RES_BANK = NB % 2;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic          iSTART;
    logic          oBUSY;
    logic          oDONE;
    logic          oRD_EN;
    logic [NB-1:0] oRD_ADDR_0;
    logic [NB-1:0] oRD_ADDR_1;
    logic [NB-1:0] oRD_ADDR_2;
    logic [NB-2:0] oROM_ADDR;
    logic          oWR_EN;
    logic [NB-1:0] oWR_ADDR_0;
    logic [NB-1:0] oWR_ADDR_1;
    logic          oBANK;
    logic [1:0]    oSTAGE;

    typedef struct {
        bit busy; bit done; bit rd_en; bit wr_en; bit bank;
        int stage; int rd0; int rd1; int rd2; int rom; int wa0; int wa1;
    } obs_t;

    typedef struct {
        int stage; int rd0; int rd1; int rd2; int rom; int bank; int wa0; int wa1;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t rec [0:DONE_J+1];
    vec_t tbl [12];

    always #5 iCLK = ~iCLK;

    fht_stage_seq #(
        .N_BIT  (NB),
        .RD_LAT (1),
        .BUT_LAT(1)
    ) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSTART    (iSTART),
        .oBUSY     (oBUSY),
        .oDONE     (oDONE),
        .oRD_EN    (oRD_EN),
        .oRD_ADDR_0(oRD_ADDR_0),
        .oRD_ADDR_1(oRD_ADDR_1),
        .oRD_ADDR_2(oRD_ADDR_2),
        .oROM_ADDR (oROM_ADDR),
        .oWR_EN    (oWR_EN),
        .oWR_ADDR_0(oWR_ADDR_0),
        .oWR_ADDR_1(oWR_ADDR_1),
        .oBANK     (oBANK),
        .oSTAGE    (oSTAGE)
    );

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy  = oBUSY;
        o.done  = oDONE;
        o.rd_en = oRD_EN;
        o.wr_en = oWR_EN;
        o.bank  = oBANK;
        o.stage = int'(oSTAGE);
        o.rd0   = int'(oRD_ADDR_0);
        o.rd1   = int'(oRD_ADDR_1);
        o.rd2   = int'(oRD_ADDR_2);
        o.rom   = int'(oROM_ADDR);
        o.wa0   = int'(oWR_ADDR_0);
        o.wa1   = int'(oWR_ADDR_1);
        return o;
    endfunction

    function automatic int all_bits(obs_t o);
        return int'(o.busy) + int'(o.done) + int'(o.rd_en) + int'(o.wr_en) + int'(o.bank)
             + o.stage + o.rd0 + o.rd1 + o.rd2 + o.rom + o.wa0 + o.wa1;
    endfunction

    function automatic int brev(int v);
        int r = 0;
        for (int i = 0; i < NB; i++) begin
            if ((v & (1 << i)) != 0) r = r | (1 << (NB - 1 - i));
        end
        return r;
    endfunction

    // Expected outputs j cycles after the accepted start edge (j=1: first read).
    function automatic obs_t model(int j);
        obs_t e = '{default: 0};
        int jr, s, p, h, g, k;
        if (j >= 1 && j <= NB * SPS) begin
            s = (j - 1) / SPS;
            p = (j - 1) % SPS;
            e.busy  = 1'b1;
            e.stage = s;
            e.bank  = ((s % 2) == 1);
            if (p < NH) begin
                h = 1 << s;
                g = (p / h) * 2 * h;
                k = p % h;
                e.rd_en = 1'b1;
                e.rd0   = g + k;
                e.rd1   = g + h + k;
                e.rd2   = (k == 0) ? g + h : g + 2 * h - k;
                e.rom   = k * (NH / h);
                if (s == 0) begin
                    e.rd0 = brev(e.rd0);
                    e.rd1 = brev(e.rd1);
                    e.rd2 = brev(e.rd2);
                end
            end
        end else if (j == DONE_J) begin
            e.busy = 1'b1;
            e.done = 1'b1;
            e.bank = (RES_BANK != 0);
        end else if (j > DONE_J) begin
            e.bank = (RES_BANK != 0);
        end
        jr = j - PL;
        if (jr >= 1 && jr <= NB * SPS && ((jr - 1) % SPS) < NH) begin
            s = (jr - 1) / SPS;
            p = (jr - 1) % SPS;
            h = 1 << s;
            g = (p / h) * 2 * h;
            k = p % h;
            e.wr_en = 1'b1;
            e.wa0   = g + k;
            e.wa1   = g + h + k;
        end
        return e;
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic cmp(string name, int j, obs_t a, obs_t e);
        bit ok;
        ok = (a.busy == e.busy) && (a.done == e.done) && (a.rd_en == e.rd_en)
          && (a.wr_en == e.wr_en) && (a.bank == e.bank);
        if (e.busy && !e.done && a.stage != e.stage) ok = 1'b0;
        if (e.rd_en && (a.rd0 != e.rd0 || a.rd1 != e.rd1 || a.rd2 != e.rd2 || a.rom != e.rom)) ok = 1'b0;
        if (e.wr_en && (a.wa0 != e.wa0 || a.wa1 != e.wa1)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d got busy=%0d done=%0d rd=%0d(%0d,%0d,%0d) rom=%0d wr=%0d(%0d,%0d) bank=%0d stg=%0d | required busy=%0d done=%0d rd=%0d(%0d,%0d,%0d) rom=%0d wr=%0d(%0d,%0d) bank=%0d stg=%0d",
                     name, j, a.busy, a.done, a.rd_en, a.rd0, a.rd1, a.rd2, a.rom, a.wr_en, a.wa0, a.wa1, a.bank, a.stage,
                     e.busy, e.done, e.rd_en, e.rd0, e.rd1, e.rd2, e.rom, e.wr_en, e.wa0, e.wa1, e.bank, e.stage);
        end
    endtask

    task automatic abort_check(int id);
        obs_t o;
        iSTART = 1'b0;
        #2;
        iRESET = 1'b0;
        #1;
        o = sample();
        chk($sformatf("async_reset_run%0d", id), all_bits(o), 0);
        tick();
        tick();
        @(negedge iCLK);
        iRESET = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            o = sample();
            chk("post_reset_idle", int'(o.busy) + int'(o.rd_en) + int'(o.wr_en) + int'(o.done), 0);
            tick();
        end
        $display("run %0d aborted by reset: checks=%0d errors=%0d", id, checks, errors);
    endtask

    task automatic run_one(int id, int stray_pct, int abort_j);
        obs_t o;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        for (int j = 1; j <= DONE_J + 1; j++) begin
            if (j == abort_j) begin
                abort_check(id);
                return;
            end
            o = sample();
            rec[j] = o;
            cmp($sformatf("run%0d", id), j, o, model(j));
            if (j < DONE_J) iSTART = ($urandom_range(99) < stray_pct) ? 1'b1 : 1'b0;
            else            iSTART = 1'b0;
            tick();
        end
        $display("run %0d complete: checks=%0d errors=%0d", id, checks, errors);
    endtask

    initial begin
        obs_t o;
        int   rd_cyc [12];
        int   wr_cyc [12];
        int   rd_n, wr_n, cnt, done_j;

        tbl[0]  = '{0, 0, 4, 4, 0, 0, 0, 1};
        tbl[1]  = '{0, 2, 6, 6, 0, 0, 2, 3};
        tbl[2]  = '{0, 1, 5, 5, 0, 0, 4, 5};
        tbl[3]  = '{0, 3, 7, 7, 0, 0, 6, 7};
        tbl[4]  = '{1, 0, 2, 2, 0, 1, 0, 2};
        tbl[5]  = '{1, 1, 3, 3, 2, 1, 1, 3};
        tbl[6]  = '{1, 4, 6, 6, 0, 1, 4, 6};
        tbl[7]  = '{1, 5, 7, 7, 2, 1, 5, 7};
        tbl[8]  = '{2, 0, 4, 4, 0, 0, 0, 4};
        tbl[9]  = '{2, 1, 5, 7, 1, 0, 1, 5};
        tbl[10] = '{2, 2, 6, 6, 2, 0, 2, 6};
        tbl[11] = '{2, 3, 7, 5, 3, 0, 3, 7};
        for (int j = 0; j <= DONE_J + 1; j++) rec[j] = '{default: 0};

        iRESET = 1'b0;
        iSTART = 1'b0;
        tick();
        tick();
        o = sample();
        chk("reset_state", all_bits(o), 0);
        @(negedge iCLK);
        iRESET = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            o = sample();
            chk("idle_no_activity", int'(o.busy) + int'(o.rd_en) + int'(o.wr_en), 0);
            tick();
        end

        // Directed run with stray iSTART pulses, then the spec vector table.
        run_one(0, 35, 0);
        rd_n = 0;
        wr_n = 0;
        for (int i = 0; i < 12; i++) begin
            rd_cyc[i] = 0;
            wr_cyc[i] = 0;
        end
        for (int j = 1; j <= DONE_J + 1; j++) begin
            if (rec[j].rd_en) begin
                if (rd_n < 12) rd_cyc[rd_n] = j;
                rd_n++;
            end
            if (rec[j].wr_en) begin
                if (wr_n < 12) wr_cyc[wr_n] = j;
                wr_n++;
            end
        end
        chk("read_count", rd_n, 12);
        chk("write_count_total", wr_n, 12);
        for (int i = 0; i < 12; i++) begin
            o = rec[rd_cyc[i]];
            chk($sformatf("tbl%0d_rd_cycle", i), rd_cyc[i], 1 + (i / 4) * SPS + (i % 4));
            chk($sformatf("tbl%0d_stage", i), o.stage, tbl[i].stage);
            chk($sformatf("tbl%0d_rd0", i), o.rd0, tbl[i].rd0);
            chk($sformatf("tbl%0d_rd1", i), o.rd1, tbl[i].rd1);
            chk($sformatf("tbl%0d_rd2", i), o.rd2, tbl[i].rd2);
            chk($sformatf("tbl%0d_rom", i), o.rom, tbl[i].rom);
            chk($sformatf("tbl%0d_bank", i), int'(o.bank), tbl[i].bank);
            o = rec[wr_cyc[i]];
            chk($sformatf("tbl%0d_wr_cycle", i), wr_cyc[i], rd_cyc[i] + 2);
            chk($sformatf("tbl%0d_wa0", i), o.wa0, tbl[i].wa0);
            chk($sformatf("tbl%0d_wa1", i), o.wa1, tbl[i].wa1);
        end
        for (int s = 0; s < NB; s++) begin
            cnt = 0;
            for (int j = s * SPS + 3; j <= s * SPS + SPS + 2; j++) if (rec[j].wr_en) cnt++;
            chk($sformatf("stage%0d_write_count", s), cnt, 4);
        end
        cnt = 0;
        for (int j = 1; j <= NB * SPS; j++) if (((j - 1) % SPS) >= NH && rec[j].rd_en) cnt++;
        chk("rd_en_during_flush", cnt, 0);
        cnt = 0;
        for (int j = 1; j <= NB * SPS; j++) if (((j - 1) % SPS) < 2 && rec[j].wr_en) cnt++;
        chk("wr_en_first_two_cycles", cnt, 0);
        done_j = 0;
        for (int j = DONE_J + 1; j >= 1; j--) if (rec[j].done) done_j = j;
        chk("done_cycle", done_j, 19);
        chk("busy_after_done", int'(rec[DONE_J + 1].busy), 0);
        o = sample();
        chk("result_bank_idle", int'(o.bank), 1);

        // iSTART held high through DONE restarts on the following IDLE cycle.
        iSTART = 1'b1;
        tick();
        for (int j = 1; j <= DONE_J + 1; j++) begin
            o = sample();
            cmp("hold_run1", j, o, model(j));
            tick();
        end
        o = sample();
        cmp("hold_restart", 1, o, model(1));
        iSTART = 1'b0;
        tick();
        for (int j = 2; j <= DONE_J + 1; j++) begin
            o = sample();
            cmp("hold_run2", j, o, model(j));
            tick();
        end
        $display("hold-start sequence complete: checks=%0d errors=%0d", checks, errors);

        // Reset asserted mid stage 1.
        run_one(1, 0, SPS + 3);

        for (int it = 0; it < 10; it++) begin
            int gap;
            int abort_j;
            gap = int'($urandom_range(3));
            for (int i = 0; i < gap; i++) begin
                o = sample();
                chk("gap_idle", int'(o.busy) + int'(o.rd_en) + int'(o.wr_en), 0);
                tick();
            end
            abort_j = ($urandom_range(2) == 0) ? int'($urandom_range(DONE_J, 2)) : 0;
            run_one(it + 2, 30, abort_j);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
